// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : RV32 fetch stage. Owns the PC, issues reads to instruction
//            memory and buffers tagged words for decode; supports redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READ_DATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        ID_READY,
  output logic        ID_VALID,
  output logic [31:0] ID_INSTRUCTION,
  output logic [31:0] ID_PC,
  output logic        ALIGN_ERR,
  output logic [31:0] FETCH_COUNT
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [c_ptr_w-1:0] c_ptr_one   = 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one   = 1;
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w:0]   c_depth_occ = (c_cnt_w + 1)'(FIFO_DEPTH);

  logic [31:0]        r_pc;
  logic               r_resp_v;
  logic [31:0]        r_resp_pc;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_align_err;
  logic [31:0]        r_fetch_count;

  logic [31:0] r_fifo_insn [FIFO_DEPTH];
  logic [31:0] r_fifo_pc   [FIFO_DEPTH];

  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [c_cnt_w:0]   w_occ;
  logic [c_cnt_w-1:0] w_count_nxt;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && ID_READY;
  assign w_push  = r_resp_v && !BRANCH_TAKEN;

  // Occupancy seen after this edge, counting the response still in flight,
  // so a new request is only made when its data is guaranteed a slot.
  assign w_occ   = {1'b0, r_count}
                 + {{c_cnt_w{1'b0}}, r_resp_v}
                 - {{c_cnt_w{1'b0}}, w_pop};
  assign w_issue = !IMEM_BUSYWAIT && !BRANCH_TAKEN && (w_occ < c_depth_occ);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc          <= RESET_PC;
      r_resp_v      <= 1'b0;
      r_resp_pc     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_align_err   <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_align_err <= BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
      if (w_pop) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (BRANCH_TAKEN) begin
        r_pc     <= {BRANCH_TARGET[31:2], 2'b00};
        r_resp_v <= 1'b0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_resp_v <= w_issue;
        if (w_issue) begin
          r_resp_pc <= r_pc;
          r_pc      <= r_pc + 32'd4;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
        r_count <= w_count_nxt;
      end
    end
  end

  // Buffer storage carries no reset; only entries below r_count are visible.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_insn[r_wr_ptr] <= IMEM_READ_DATA;
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  assign IMEM_ADDRESS   = r_pc;
  assign ID_VALID       = w_valid;
  assign ID_INSTRUCTION = w_valid ? r_fifo_insn[r_rd_ptr] : NOP_INSN;
  assign ID_PC          = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0000_0000;
  assign ALIGN_ERR      = r_align_err;
  assign FETCH_COUNT    = r_fetch_count;

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET)
    !(w_push && !w_pop && (r_count == c_depth_cnt)));

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Self-checking bench for instruction_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [31:0] c_reset_pc = 32'h0000_0000;
  localparam logic [31:0] c_nop      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        busy;
  logic        branch;
  logic [31:0] target;
  logic        ready;
  logic        id_valid;
  logic [31:0] id_insn;
  logic [31:0] id_pc;
  logic        align_err;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit #(
    .RESET_PC  (c_reset_pc),
    .FIFO_DEPTH(2),
    .NOP_INSN  (c_nop)
  ) dut (
    .CLK           (clk),
    .RESET         (rst_n),
    .IMEM_ADDRESS  (imem_addr),
    .IMEM_READ_DATA(imem_rdata),
    .IMEM_BUSYWAIT (busy),
    .BRANCH_TAKEN  (branch),
    .BRANCH_TARGET (target),
    .ID_READY      (ready),
    .ID_VALID      (id_valid),
    .ID_INSTRUCTION(id_insn),
    .ID_PC         (id_pc),
    .ALIGN_ERR     (align_err),
    .FETCH_COUNT   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0090_0093;
    if (a == 32'h0000_0004) return 32'h0050_0113;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Registered-read memory: data appears one clock after the address.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        busy;
    logic        ready;
    logic        branch;
    logic [31:0] target;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_cnt;
    logic        exp_align;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic b, input logic rd, input logic br,
                              input logic [31:0] t, input logic v, input logic [31:0] pc,
                              input logic [31:0] ad, input logic [31:0] c, input logic al);
    vec_t x;
    x.rst_n = r; x.busy = b; x.ready = rd; x.branch = br; x.target = t;
    x.exp_valid = v; x.exp_pc = pc; x.exp_addr = ad; x.exp_cnt = c; x.exp_align = al;
    return x;
  endfunction

  task automatic apply(input vec_t v, input string tag, input int idx);
    rst_n  = v.rst_n;
    busy   = v.busy;
    ready  = v.ready;
    branch = v.branch;
    target = v.target;
    @(negedge clk);
    check($sformatf("%s[%0d] valid", tag, idx), {31'b0, id_valid}, {31'b0, v.exp_valid});
    check($sformatf("%s[%0d] id_pc", tag, idx), id_pc, v.exp_pc);
    check($sformatf("%s[%0d] insn", tag, idx), id_insn, v.exp_valid ? mem_word(v.exp_pc) : c_nop);
    check($sformatf("%s[%0d] addr", tag, idx), imem_addr, v.exp_addr);
    check($sformatf("%s[%0d] count", tag, idx), fetch_cnt, v.exp_cnt);
    check($sformatf("%s[%0d] align", tag, idx), {31'b0, align_err}, {31'b0, v.exp_align});
  endtask

  vec_t start_tab [10];
  vec_t seq_tab   [14];

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_align;
    logic        prev_branch;
    logic [31:0] prev_tgt;
    logic        hold;
    logic [31:0] hold_pc;
    logic [31:0] hold_insn;
    int          idle;
    logic        nb;
    logic        nr;
    logic        nbr;
    logic [31:0] nt;

    //                 rst bsy rdy br target         v  id_pc  addr   cnt al
    start_tab[0] = mk(0, 0, 0, 0, 32'h0, 0, 32'h00, 32'h00, 0, 0);
    start_tab[1] = mk(1, 0, 1, 0, 32'h0, 0, 32'h00, 32'h04, 0, 0);
    start_tab[2] = mk(1, 0, 1, 0, 32'h0, 1, 32'h00, 32'h08, 0, 0);
    start_tab[3] = mk(1, 0, 1, 0, 32'h0, 1, 32'h04, 32'h0C, 1, 0);
    start_tab[4] = mk(1, 0, 1, 0, 32'h0, 1, 32'h08, 32'h10, 2, 0);
    start_tab[5] = mk(1, 0, 0, 0, 32'h0, 1, 32'h08, 32'h10, 2, 0);
    start_tab[6] = mk(1, 0, 0, 0, 32'h0, 1, 32'h08, 32'h10, 2, 0);
    start_tab[7] = mk(1, 0, 1, 0, 32'h0, 1, 32'h0C, 32'h14, 3, 0);
    start_tab[8] = mk(1, 0, 1, 0, 32'h0, 1, 32'h10, 32'h18, 4, 0);
    start_tab[9] = mk(1, 0, 1, 0, 32'h0, 1, 32'h14, 32'h1C, 5, 0);

    // Busywait stall and drain, then aligned and misaligned redirects.
    seq_tab[0]  = mk(1, 1, 1, 0, 32'h00, 1, 32'h18, 32'h1C, 6, 0);
    seq_tab[1]  = mk(1, 1, 1, 0, 32'h00, 0, 32'h00, 32'h1C, 7, 0);
    seq_tab[2]  = mk(1, 1, 1, 0, 32'h00, 0, 32'h00, 32'h1C, 7, 0);
    seq_tab[3]  = mk(1, 0, 1, 0, 32'h00, 0, 32'h00, 32'h20, 7, 0);
    seq_tab[4]  = mk(1, 0, 1, 0, 32'h00, 1, 32'h1C, 32'h24, 7, 0);
    seq_tab[5]  = mk(1, 0, 0, 0, 32'h00, 1, 32'h1C, 32'h24, 7, 0);
    seq_tab[6]  = mk(1, 0, 0, 1, 32'h40, 0, 32'h00, 32'h40, 7, 0);
    seq_tab[7]  = mk(1, 0, 1, 0, 32'h00, 0, 32'h00, 32'h44, 7, 0);
    seq_tab[8]  = mk(1, 0, 1, 0, 32'h00, 1, 32'h40, 32'h48, 7, 0);
    seq_tab[9]  = mk(1, 0, 1, 0, 32'h00, 1, 32'h44, 32'h4C, 8, 0);
    seq_tab[10] = mk(1, 0, 1, 1, 32'h46, 0, 32'h00, 32'h44, 9, 1);
    seq_tab[11] = mk(1, 0, 1, 0, 32'h00, 0, 32'h00, 32'h48, 9, 0);
    seq_tab[12] = mk(1, 0, 1, 0, 32'h00, 1, 32'h44, 32'h4C, 9, 0);
    seq_tab[13] = mk(1, 0, 0, 0, 32'h00, 1, 32'h44, 32'h4C, 9, 0);

    rst_n = 1'b0; busy = 1'b0; ready = 1'b0; branch = 1'b0; target = '0;
    repeat (2) @(negedge clk);
    check("reset valid", {31'b0, id_valid}, 32'd0);
    check("reset insn", id_insn, c_nop);
    check("reset id_pc", id_pc, 32'd0);
    check("reset addr", imem_addr, c_reset_pc);
    check("reset count", fetch_cnt, 32'd0);
    check("reset align", {31'b0, align_err}, 32'd0);

    for (int i = 0; i < 10; i++) apply(start_tab[i], "start", i);
    for (int i = 0; i < 14; i++) apply(seq_tab[i], "seq", i);

    // Asynchronous reset with two entries buffered.
    check("pre-reset valid", {31'b0, id_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async valid", {31'b0, id_valid}, 32'd0);
    check("async count", fetch_cnt, 32'd0);
    check("async addr", imem_addr, c_reset_pc);
    check("async insn", id_insn, c_nop);
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
    @(negedge clk);
    check("restart addr", imem_addr, c_reset_pc + 32'd4);
    check("restart valid0", {31'b0, id_valid}, 32'd0);
    @(negedge clk);
    check("restart valid1", {31'b0, id_valid}, 32'd1);
    check("restart id_pc", id_pc, c_reset_pc);
    check("restart insn", id_insn, mem_word(c_reset_pc));

    // Randomized run against a stream-level model: delivered PCs form a
    // +4 sequence restarting at each aligned redirect target.
    rst_n = 1'b0; ready = 1'b0; busy = 1'b0; branch = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = c_reset_pc; exp_cnt = 0; exp_align = 1'b0;
    prev_branch = 1'b0; prev_tgt = '0; hold = 1'b0; hold_pc = '0; hold_insn = '0; idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd count", fetch_cnt, exp_cnt);
      check("rnd align", {31'b0, align_err}, {31'b0, exp_align});
      if (prev_branch) begin
        check("rnd flush valid", {31'b0, id_valid}, 32'd0);
        check("rnd redirect addr", imem_addr, {prev_tgt[31:2], 2'b00});
      end
      if (hold) begin
        check("rnd hold valid", {31'b0, id_valid}, 32'd1);
        check("rnd hold pc", id_pc, hold_pc);
        check("rnd hold insn", id_insn, hold_insn);
      end

      nb  = ($urandom_range(0, 3) == 0);
      nr  = ($urandom_range(0, 3) != 0);
      nbr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) nt = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
      else                           nt = 32'($urandom_range(0, 1023));

      if (id_valid && nr) begin
        check("rnd pop pc", id_pc, exp_pc);
        check("rnd pop insn", id_insn, mem_word(exp_pc));
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
        idle    = 0;
      end else begin
        idle++;
        if (idle > 60) begin
          check("rnd liveness", 32'(idle), 32'd0);
          idle = 0;
        end
      end
      if (nbr) begin
        exp_pc = {nt[31:2], 2'b00};
        idle   = 0;
      end

      hold      = id_valid && !nr && !nbr;
      hold_pc   = id_pc;
      hold_insn = id_insn;
      exp_align = nbr && (nt[1:0] != 2'b00);
      prev_branch = nbr;
      prev_tgt    = nt;

      busy = nb; ready = nr; branch = nbr; target = nt;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
